piso_stream: RTL and testbench
==============================

// Module: piso_stream
// PURPOSE
//  Parallel-in/serial-out shifter with a valid/ready input handshake.
//  It has a one-word holding buffer, so the serial stream runs back-to-back with no gap.
//  It also has a shift-enable input for bit-rate pacing, a selectable bit order and an abort.
//  It sits between a word-wide producer and a serial line driver, for example a UART/SPI-style TX.
// PARAMETERS
//  N          8   data word width, in bits; N >= 2
//  MSB_FIRST  0   0: bit 0 is sent first; 1: bit N-1 is sent first
//  IDLE_LEVEL 0   level driven on ser_out when no bit is valid
// PORTS
//  clk         in   1        clock; all logic acts on the rising edge
//  rst         in   1        synchronous reset, active-low; sampled only on the clk rising edge
//  in_valid    in   1        in_data is valid
//  in_data     in   N        parallel word to serialise
//  in_ready    out  1        block can accept a word this cycle
//  shift_en    in   1        advance-one-bit strobe (tie to 1 for full rate)
//  abort       in   1        synchronous flush of the current frame and the buffer
//  ser_out     out  1        serial data
//  ser_valid   out  1        ser_out carries a valid bit
//  frame_start out  1        ser_valid and the current bit is the first bit of the word
//  frame_end   out  1        ser_valid and the current bit is the last bit of the word
//  busy        out  1        ser_valid | hold_full
// BEHAVIOUR
//  State: hold register + hold_full flag; shift register; bit counter cnt[$clog2(N)-1:0]; ser_valid flag.
//  Shifter states: IDLE (ser_valid=0) and SHIFT (ser_valid=1).
//  Priority on each edge: rst=0 > abort=1 > normal operation.
//  Reset (rst=0 at an edge):
//   - hold_full=0, shift register=0, cnt=0, ser_valid=0.
//   - Outputs: ser_out=IDLE_LEVEL, in_ready=1, frame_start=0, frame_end=0, busy=0.
//   - Applies mid-frame with no partial bits emitted afterwards.
//  abort=1 at an edge: same register result as reset. in_ready=0 while abort=1, so no word is accepted.
//  in_ready = ~hold_full & ~abort. It is combinational from registers and does not depend on in_valid.
//  Accept: in_valid & in_ready at edge E0 -> the word is written to hold and hold_full=1.
//  Load hold -> shifter happens at an edge when hold_full=1 and either condition holds:
//   (a) the shifter is IDLE (shift_en is ignored), or
//   (b) SHIFT, cnt==N-1 and shift_en=1 (last-bit advance).
//   On load: cnt=0, ser_valid=1, hold_full=0.
//   Hold can accept a new word on that same edge only if in_ready was 1 before the edge.
//  Latency: accept at E0, idle shifter -> first bit valid from E1 (2-flop path, 1 cycle after the accepting edge).
//  Bit advance in SHIFT at an edge with shift_en=1:
//   - cnt < N-1: cnt+1, and the register shifts toward the output end.
//   - cnt==N-1: load the next word if hold_full; else ser_valid=0 (go to IDLE).
//  shift_en=0 in SHIFT: all shifter state holds, and the current bit stays on ser_out.
//  ser_out = ser_valid ? current bit : IDLE_LEVEL.
//   - The current bit is the register LSB when MSB_FIRST=0, and the register MSB when MSB_FIRST=1.
//  frame_start = ser_valid & (cnt==0); frame_end = ser_valid & (cnt==N-1). Both are combinational.
//  Throughput: one word per N shift_en-qualified edges.
//   - There is no idle gap between words while hold refills in time.
//  Full buffer: hold_full=1 and SHIFT -> in_ready=0 until the load edge; then in_ready=1 in the next cycle.
//  The counter never exceeds N-1. There is no wrap other than the load/return-to-IDLE at N-1.
// TESTING
//  1. Reset: hold rst=0 for 2 edges with in_valid=1.
//     -> ser_valid=0, ser_out=IDLE_LEVEL, busy=0, in_ready=1; no word captured.
//  2. N=8, MSB_FIRST=0, shift_en=1, send 0xA5.
//     -> ser_out=1,0,1,0,0,1,0,1 on 8 consecutive cycles, starting the cycle after accept.
//     -> frame_start on bit 1 only, frame_end on bit 8 only; then ser_valid=0.
//  3. MSB_FIRST=1, send 0xA5, then 0x3C with in_valid held.
//     -> 16 contiguous valid bits 10100101 00111100 with no gap.
//     -> in_ready=0 from after the 2nd accept until the 0x3C load edge.
//  4. shift_en alternating 1/0, send 0xF0.
//     -> each bit is held 2 cycles, the frame spans 16 cycles, and the bit order is unchanged.
//  5. abort=1 for 1 cycle at bit 4 of 0xA5, with 0x3C waiting in hold and in_valid=1.
//     -> next cycle ser_valid=0, busy=0, ser_out=IDLE_LEVEL; 0x3C is never sent.
//     -> no accept during abort; in_ready=1 after abort.
//  6. rst=0 for 1 edge at bit 5 of a frame.
//     -> all outputs are at reset values the next cycle.
//     -> a word sent afterwards is serialised correctly from bit 0.

Source files
------------

// File: rtl/piso_stream.sv
// Parallel-in/serial-out shifter with a one-word holding buffer, valid/ready input,
// shift-enable pacing, selectable bit order and a synchronous frame abort.
module piso_stream #(
    parameter int N          = 8,
    parameter bit MSB_FIRST  = 1'b0,
    parameter bit IDLE_LEVEL = 1'b0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    input  logic [N-1:0] in_data,
    output logic         in_ready,
    input  logic         shift_en,
    input  logic         abort,
    output logic         ser_out,
    output logic         ser_valid,
    output logic         frame_start,
    output logic         frame_end,
    output logic         busy
);

    localparam int CW = $clog2(N);
    localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);
    localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    state_t        state_r, state_s;
    logic [N-1:0]  hold_r, hold_s;
    logic [N-1:0]  shreg_r, shreg_s;
    logic          hold_full_r, hold_full_s;
    logic [CW-1:0] cnt_r, cnt_s;
    logic          accept_s;
    logic          last_s;
    logic          cur_bit_s;

    assign in_ready    = ~hold_full_r & ~abort;
    assign accept_s    = in_valid & in_ready;
    assign last_s      = (cnt_r == CNT_LAST);
    assign cur_bit_s   = MSB_FIRST ? shreg_r[N-1] : shreg_r[0];
    assign ser_valid   = (state_r == ST_SHIFT);
    assign ser_out     = ser_valid ? cur_bit_s : IDLE_LEVEL;
    assign frame_start = ser_valid & (cnt_r == CNT_ZERO);
    assign frame_end   = ser_valid & last_s;
    assign busy        = ser_valid | hold_full_r;

    // Next-state logic: hold->shifter load, bit advance and word acceptance.
    always_comb begin
        state_s     = state_r;
        hold_s      = hold_r;
        hold_full_s = hold_full_r;
        shreg_s     = shreg_r;
        cnt_s       = cnt_r;
        case (state_r)
            ST_IDLE: begin
                if (hold_full_r) begin
                    shreg_s     = hold_r;
                    cnt_s       = CNT_ZERO;
                    hold_full_s = 1'b0;
                    state_s     = ST_SHIFT;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                if (shift_en) begin
                    if (last_s) begin
                        // Last bit leaves: chain straight into the buffered word if there is one.
                        if (hold_full_r) begin
                            shreg_s     = hold_r;
                            cnt_s       = CNT_ZERO;
                            hold_full_s = 1'b0;
                            state_s     = ST_SHIFT;
                        end else begin
                            state_s = ST_IDLE;
                        end
                    end else begin
                        cnt_s = cnt_r + CW'(1);
                        if (MSB_FIRST) begin
                            shreg_s = {shreg_r[N-2:0], 1'b0};
                        end else begin
                            shreg_s = {1'b0, shreg_r[N-1:1]};
                        end
                    end
                end else begin
                    state_s = ST_SHIFT;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
        // Acceptance needs an empty hold, so it never collides with a load in the same cycle.
        if (accept_s) begin
            hold_s      = in_data;
            hold_full_s = 1'b1;
        end else begin
            hold_full_s = hold_full_s;
        end
    end

    // State registers; reset and abort both flush the frame and the buffer.
    always_ff @(posedge clk) begin
        if (!rst || abort) begin
            state_r     <= ST_IDLE;
            hold_r      <= {N{1'b0}};
            hold_full_r <= 1'b0;
            shreg_r     <= {N{1'b0}};
            cnt_r       <= CNT_ZERO;
        end else begin
            state_r     <= state_s;
            hold_r      <= hold_s;
            hold_full_r <= hold_full_s;
            shreg_r     <= shreg_s;
            cnt_r       <= cnt_s;
        end
    end

endmodule

// File: tb/tb_piso_stream.sv
// Scoreboard bench for piso_stream: an LSB-first and an MSB-first instance share stimulus;
// accepted words push expected bits, a negedge monitor pops and compares.
module tb_piso_stream;

    localparam int N = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic [N-1:0] in_data;
    logic         shift_en;
    logic         abort;

    logic rdy0, so0, sv0, fs0, fe0, busy0;
    logic rdy1, so1, sv1, fs1, fe1, busy1;

    int n_checks = 0;
    int n_fail   = 0;
    bit mon_en   = 1'b0;
    int run_cur  = 0;
    int run_max  = 0;
    // Entry: {lsb-first bit, msb-first bit, frame_start, frame_end}
    logic [3:0] exp_q[$];

    always #5 clk = ~clk;

    piso_stream #(.N(N), .MSB_FIRST(1'b0), .IDLE_LEVEL(1'b0)) dut0 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(rdy0),
        .shift_en(shift_en), .abort(abort), .ser_out(so0), .ser_valid(sv0),
        .frame_start(fs0), .frame_end(fe0), .busy(busy0)
    );

    piso_stream #(.N(N), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b1)) dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(rdy1),
        .shift_en(shift_en), .abort(abort), .ser_out(so1), .ser_valid(sv1),
        .frame_start(fs1), .frame_end(fe1), .busy(busy1)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_word(input logic [N-1:0] w);
        for (int i = 0; i < N; i++) begin
            exp_q.push_back({w[i], w[N-1-i], (i == 0), (i == N-1)});
        end
    endtask

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic send(input logic [N-1:0] w);
        int t;
        in_data  = w;
        in_valid = 1'b1;
        t = 0;
        @(negedge clk);
        while (!rdy0 && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (!rdy0) begin
            check("send_ready_timeout", 32'd0, 32'd1);
            @(posedge clk);
            #1;
        end else begin
            @(posedge clk);
            push_word(w);
            #1;
        end
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (exp_q.size() > 0 && t < 200) begin
            @(posedge clk);
            t++;
        end
        repeat (2) @(posedge clk);
        #1;
        check("drain_empty", exp_q.size(), 32'd0);
    endtask

    task automatic check_flushed(input string name);
        @(negedge clk);
        check({name, "_lsb"}, {sv0, so0, busy0, rdy0, fs0, fe0}, {1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0});
        check({name, "_msb"}, {sv1, so1, busy1, rdy1, fs1, fe1}, {1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0});
    endtask

    // Monitor: compare every presented bit against the scoreboard head.
    always @(negedge clk) begin
        logic [3:0] e;
        if (mon_en) begin
            if (sv0) begin
                run_cur++;
                if (run_cur > run_max) run_max = run_cur;
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_bit: ser_valid=1 with empty scoreboard at %0t", $time);
                end else begin
                    e = exp_q[0];
                    check("bit_lsb_first", {so0, fs0, fe0}, {e[3], e[1], e[0]});
                    check("bit_msb_first", {sv1, so1, fs1, fe1}, {1'b1, e[2], e[1], e[0]});
                    if (shift_en) void'(exp_q.pop_front());
                end
            end else begin
                run_cur = 0;
                check("idle_outputs", {so0, fs0, fe0, sv1, so1, fs1, fe1},
                      {1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int ir_low;
        rst      = 1'b0;
        in_valid = 1'b1;
        in_data  = 8'h5A;
        shift_en = 1'b1;
        abort    = 1'b0;

        // Reset held for 2 edges with in_valid high
        repeat (2) @(posedge clk);
        check_flushed("reset");
        mon_en = 1'b1;
        @(posedge clk);
        #1;
        rst      = 1'b1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        check("reset_no_capture", {busy0, busy1}, {1'b0, 1'b0});
        @(posedge clk);
        #1;

        // Single word at full rate
        run_max = 0;
        send(8'hA5);
        in_valid = 1'b0;
        drain();
        check("single_frame_len", run_max, 32'd8);

        // Back-to-back words with in_valid held
        run_max = 0;
        send(8'hA5);
        send(8'h3C);
        in_valid = 1'b0;
        ir_low = 0;
        @(negedge clk);
        while (!rdy0 && ir_low < 50) begin
            ir_low++;
            @(negedge clk);
        end
        check("full_buffer_ready_low", ir_low, 32'd7);
        @(posedge clk);
        #1;
        drain();
        check("back_to_back_len", run_max, 32'd16);

        // Paced by alternating shift_en
        run_max = 0;
        send(8'hF0);
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        shift_en = 1'b0;
        repeat (20) begin
            @(posedge clk);
            #1;
            shift_en = ~shift_en;
        end
        shift_en = 1'b1;
        drain();
        check("paced_frame_len", run_max, 32'd16);

        // Abort at bit 4 with 0x3C buffered
        send(8'hA5);
        send(8'h3C);
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        abort   = 1'b1;
        in_data = 8'h77;
        @(negedge clk);
        check("abort_ready_low", {rdy0, rdy1}, {1'b0, 1'b0});
        @(posedge clk);
        #1;
        abort    = 1'b0;
        in_valid = 1'b0;
        exp_q.delete();
        check_flushed("abort");
        repeat (20) @(posedge clk);
        @(negedge clk);
        check("abort_no_resend", {busy0, busy1}, {1'b0, 1'b0});
        @(posedge clk);
        #1;

        // Reset pulse at bit 5, then a clean frame
        send(8'h5A);
        in_valid = 1'b0;
        repeat (5) begin
            @(posedge clk);
            #1;
        end
        rst = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        exp_q.delete();
        check_flushed("midframe_reset");
        @(posedge clk);
        #1;
        run_max = 0;
        send(8'hC3);
        in_valid = 1'b0;
        drain();
        check("post_reset_frame_len", run_max, 32'd8);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
